sync_fifo_ctrl: RTL and testbench

Pointer and flag controller for the synchronous FIFO; sits directly upstream of `dual_port_ram` and drives its write/read ports from a single clock. Accepts push/pop requests from the user side, gates them against full/empty, generates RAM addresses and enables, and tracks occupancy. RAM read data returns on `rdata` one cycle after an accepted pop; `rd_valid` from this block qualifies it.

---
 rtl/sync_fifo_ctrl.sv | 114 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - pointer, occupancy and flag controller driving a dual-port RAM FIFO
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 6,
    parameter int AFULL_THRESH  = 60,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  rd_valid,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    // Pointers carry one extra wrap bit above the RAM address.
    logic [CW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_valid_q, rd_valid_d;

    logic          wr_acc;
    logic          rd_acc;

    // Accept decisions use this cycle's registered flags; reset blocks both RAM ports.
    always_comb begin
        wr_acc = wr_en & ~full_q & ~rst;
        rd_acc = rd_en & ~empty_q & ~rst;
    end

    // Next-state: pointer/count advance, flags from the next count, one-cycle pulses.
    always_comb begin
        wptr_d         = wptr_q + {{(CW-1){1'b0}}, wr_acc};
        rptr_d         = rptr_q + {{(CW-1){1'b0}}, rd_acc};
        count_d        = count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AFULL_C);
        almost_empty_d = (count_d <= AEMPTY_C);
        overflow_d     = wr_en & full_q;
        underflow_d    = rd_en & empty_q;
        rd_valid_d     = rd_acc;
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

    // RAM port drive and status outputs; the read and write addresses never collide
    // because a write at full is blocked and a read at empty is blocked.
    always_comb begin
        ram_we       = wr_acc;
        ram_waddr    = wptr_q[ADDR_WIDTH-1:0];
        ram_wdata    = wr_data;
        ram_re       = rd_acc;
        ram_raddr    = rptr_q[ADDR_WIDTH-1:0];
        full         = full_q;
        empty        = empty_q;
        almost_full  = almost_full_q;
        almost_empty = almost_empty_q;
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
        rd_valid     = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - scoreboard bench for sync_fifo_ctrl with a behavioural RAM
module tb_sync_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic        full, empty, almost_full, almost_empty;
    logic [6:0]  count;
    logic        overflow, underflow, rd_valid;
    logic        ram_we, ram_re;
    logic [5:0]  ram_waddr, ram_raddr;
    logic [31:0] ram_wdata;

    sync_fifo_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .AFULL_THRESH(60), .AEMPTY_THRESH(4)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .rd_valid(rd_valid),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) rdata <= mem[ram_raddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int          m_cnt = 0;
    int          m_wptr = 0;
    int          m_rptr = 0;
    logic [31:0] fifo_q [$];
    logic [31:0] exp_data [$];
    int          exp_cyc [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every rd_valid pops the oldest expected word and checks data and latency.
    always @(negedge clk) begin
        while (exp_cyc.size() > 0 && exp_cyc[0] + 1 < cyc) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_missing actual=0 required=1 (pop cycle %0d)", exp_cyc[0]);
            void'(exp_cyc.pop_front());
            void'(exp_data.pop_front());
        end
        if (rd_valid === 1'b1) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("rd_latency", 64'(cyc), 64'(exp_cyc[0] + 1));
                chk("rdata", {32'h0, rdata}, {32'h0, exp_data[0]});
                void'(exp_cyc.pop_front());
                void'(exp_data.pop_front());
            end
        end
    end

    task automatic chk_flags();
        chk("count", {57'h0, count}, 64'(m_cnt));
        chk("full", {63'h0, full}, {63'h0, m_cnt == 64});
        chk("empty", {63'h0, empty}, {63'h0, m_cnt == 0});
        chk("almost_full", {63'h0, almost_full}, {63'h0, m_cnt >= 60});
        chk("almost_empty", {63'h0, almost_empty}, {63'h0, m_cnt <= 4});
    endtask

    // One cycle of stimulus: predict accepts, check RAM drive, queue expected reads.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        logic was_full, was_empty, wacc, racc;
        was_full  = (m_cnt == 64);
        was_empty = (m_cnt == 0);
        wacc = w && !was_full;
        racc = r && !was_empty;
        wr_en = w;
        rd_en = r;
        wr_data = d;
        @(negedge clk);
        chk("ram_we", {63'h0, ram_we}, {63'h0, wacc});
        chk("ram_re", {63'h0, ram_re}, {63'h0, racc});
        if (wacc) begin
            chk("ram_waddr", {58'h0, ram_waddr}, 64'(m_wptr % 64));
            chk("ram_wdata", {32'h0, ram_wdata}, {32'h0, d});
        end
        if (racc) begin
            chk("ram_raddr", {58'h0, ram_raddr}, 64'(m_rptr % 64));
            exp_data.push_back(fifo_q.pop_front());
            exp_cyc.push_back(cyc);
        end
        if (wacc) fifo_q.push_back(d);
        @(posedge clk);
        #1;
        m_cnt  = m_cnt + int'(wacc) - int'(racc);
        m_wptr = (m_wptr + int'(wacc)) % 128;
        m_rptr = (m_rptr + int'(racc)) % 128;
        chk_flags();
        chk("overflow", {63'h0, overflow}, {63'h0, w && was_full});
        chk("underflow", {63'h0, underflow}, {63'h0, r && was_empty});
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Reset cycle with optional push/pop requests pending; both must be blocked.
    task automatic step_rst(input logic w, input logic r);
        rst = 1'b1;
        wr_en = w;
        rd_en = r;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_ram_we", {63'h0, ram_we}, 64'h0);
        chk("rst_ram_re", {63'h0, ram_re}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        m_cnt = 0;
        m_wptr = 0;
        m_rptr = 0;
        fifo_q.delete();
        chk_flags();
        chk("rst_overflow", {63'h0, overflow}, 64'h0);
        chk("rst_underflow", {63'h0, underflow}, 64'h0);
        chk("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        @(posedge clk);
        #1;
        step_rst(1'b0, 1'b0);

        // Fill 0..63, then a rejected 65th push and an idle cycle to end the pulse.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 32'(i));
        step(1'b1, 1'b0, 32'h0BAD);
        step(1'b0, 1'b0, 32'h0);

        // Drain all 64, then a rejected extra pop.
        for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Hold occupancy at 3 while pointers wrap through address 63 -> 0.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h1000 + 32'(i));
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 32'h2000 + 32'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);

        // Simultaneous push+pop at full, then at empty.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 32'h3000 + 32'(i));
        step(1'b1, 1'b1, 32'h0BAD);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b1, 32'h4444);
        step(1'b0, 1'b1, 32'h0);

        // Write-then-read of the same entry without bypass.
        step(1'b1, 1'b0, 32'h15);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Reset mid-stream with count 20, a pop just issued and requests pending.
        for (int i = 0; i < 21; i++) step(1'b1, 1'b0, 32'h5000 + 32'(i));
        step(1'b0, 1'b1, 32'h0);
        step_rst(1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        checks++;
        if (exp_data.size() != 0) begin
            errors++;
            $display("FAIL pending_reads actual=%0d required=0", exp_data.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
